// File: rtl/pcie_axib_mem_slave.sv
// AXI4 scratch-memory slave for the XDMA bypass master: INCR/FIXED bursts,
// independent read/write engines, SLVERR on illegal bursts with a saturating counter.
module pcie_axib_mem_slave #(
  parameter int                DATA_W    = 256,
  parameter int                ADDR_W    = 32,
  parameter int                ID_W      = 4,
  parameter int                DEPTH     = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                axi_aclk,
  input  logic                axi_aresetn,
  input  logic [ID_W-1:0]     s_axi_awid,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic [1:0]          s_axi_awburst,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [ID_W-1:0]     s_axi_bid,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ID_W-1:0]     s_axi_arid,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic [1:0]          s_axi_arburst,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [ID_W-1:0]     s_axi_rid,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  output logic [15:0]         err_count
);
  localparam int                BYTES   = DATA_W / 8;
  localparam int                SZ      = $clog2(BYTES);
  localparam int                IDX_W   = $clog2(DEPTH);
  localparam logic [2:0]        C_SIZE  = 3'(SZ);
  localparam logic [ADDR_W-1:0] C_DEPTH = ADDR_W'(DEPTH);
  localparam logic [1:0]        RESP_OK = 2'b00;
  localparam logic [1:0]        RESP_SE = 2'b10;

  function automatic logic [ADDR_W-1:0] f_idx(input logic [ADDR_W-1:0] addr);
    return (addr - BASE_ADDR) >> SZ;
  endfunction

  // idx holds at most ADDR_W-SZ significant bits, so idx+len cannot overflow
  function automatic logic f_legal(input logic [ADDR_W-1:0] idx, input logic [7:0] len,
                                   input logic [2:0] size, input logic [1:0] burst);
    logic w_end_ok;
    w_end_ok = (burst == 2'b00) || ((idx + {{(ADDR_W-8){1'b0}}, len}) < C_DEPTH);
    return (size == C_SIZE) && (burst == 2'b00 || burst == 2'b01) && (idx < C_DEPTH) && w_end_ok;
  endfunction

  logic [DATA_W-1:0] r_mem [DEPTH];

  // ---------------- write engine ----------------
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  wstate_t r_wst, w_wst_nxt;

  logic              r_awready, r_wready, r_bvalid;
  logic [ID_W-1:0]   r_bid;
  logic [1:0]        r_bresp;
  logic [IDX_W-1:0]  r_widx;
  logic [7:0]        r_wcnt;
  logic              r_wfixed, r_wlegal, r_wlerr;
  logic [ADDR_W-1:0] w_aw_idx;
  logic              w_aw_legal, w_aw_hs, w_w_hs, w_b_hs, w_wlast_beat, w_wlast_err;

  assign w_aw_idx     = f_idx(s_axi_awaddr);
  assign w_aw_legal   = f_legal(w_aw_idx, s_axi_awlen, s_axi_awsize, s_axi_awburst);
  assign w_aw_hs      = s_axi_awvalid & r_awready;
  assign w_w_hs       = s_axi_wvalid & r_wready;
  assign w_b_hs       = r_bvalid & s_axi_bready;
  assign w_wlast_beat = (r_wcnt == 8'd0);
  assign w_wlast_err  = (s_axi_wlast != w_wlast_beat);

  always_comb begin
    w_wst_nxt = r_wst;
    case (r_wst)
      W_IDLE:  if (w_aw_hs) w_wst_nxt = W_DATA;
      W_DATA:  if (w_w_hs && w_wlast_beat) w_wst_nxt = W_RESP;
      W_RESP:  if (w_b_hs) w_wst_nxt = W_IDLE;
      default: w_wst_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_wst     <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bid     <= '0;
      r_bresp   <= RESP_OK;
      r_widx    <= '0;
      r_wcnt    <= '0;
      r_wfixed  <= 1'b0;
      r_wlegal  <= 1'b0;
      r_wlerr   <= 1'b0;
    end else begin
      r_wst     <= w_wst_nxt;
      r_awready <= (w_wst_nxt == W_IDLE);
      r_wready  <= (w_wst_nxt == W_DATA);
      r_bvalid  <= (w_wst_nxt == W_RESP);
      if (w_aw_hs) begin
        r_bid    <= s_axi_awid;
        r_widx   <= w_aw_idx[IDX_W-1:0];
        r_wcnt   <= s_axi_awlen;
        r_wfixed <= (s_axi_awburst == 2'b00);
        r_wlegal <= w_aw_legal;
        r_wlerr  <= 1'b0;
      end
      if (w_w_hs) begin
        r_wcnt <= r_wcnt - 8'd1;
        if (!r_wfixed) r_widx <= r_widx + IDX_W'(1);
        if (w_wlast_err) r_wlerr <= 1'b1;
        if (w_wlast_beat)
          r_bresp <= (!r_wlegal || r_wlerr || w_wlast_err) ? RESP_SE : RESP_OK;
      end
    end
  end

  // memory contents survive reset, so this port carries no reset
  always_ff @(posedge axi_aclk) begin
    if (w_w_hs && r_wlegal)
      for (int b = 0; b < BYTES; b++)
        if (s_axi_wstrb[b]) r_mem[r_widx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
  end

  // ---------------- read engine ----------------
  typedef enum logic {R_IDLE, R_BURST} rstate_t;
  rstate_t r_rst, w_rst_nxt;

  logic              r_arready, r_rvalid;
  logic [ID_W-1:0]   r_rid;
  logic [1:0]        r_rresp;
  logic [IDX_W-1:0]  r_ridx;
  logic [8:0]        r_rrem;
  logic              r_rfixed, r_rlegal;
  logic [DATA_W-1:0] r_fdata [2];
  logic [1:0]        r_flast;
  logic              r_wp, r_rp;
  logic [1:0]        r_fcnt, w_fcnt_nxt;
  logic [ADDR_W-1:0] w_ar_idx;
  logic              w_ar_legal, w_ar_hs, w_r_pop, w_r_issue, w_r_done;

  assign w_ar_idx   = f_idx(s_axi_araddr);
  assign w_ar_legal = f_legal(w_ar_idx, s_axi_arlen, s_axi_arsize, s_axi_arburst);
  assign w_ar_hs    = s_axi_arvalid & r_arready;
  assign w_r_pop    = r_rvalid & s_axi_rready;
  assign w_r_done   = w_r_pop & r_flast[r_rp];
  // the memory read lands straight in the FIFO, so room is judged after this cycle's pop
  assign w_r_issue  = (r_rst == R_BURST) && (r_rrem != 9'd0) && ((r_fcnt != 2'd2) || w_r_pop);
  assign w_fcnt_nxt = r_fcnt + 2'(w_r_issue) - 2'(w_r_pop);

  always_comb begin
    w_rst_nxt = r_rst;
    case (r_rst)
      R_IDLE:  if (w_ar_hs) w_rst_nxt = R_BURST;
      R_BURST: if (w_r_done) w_rst_nxt = R_IDLE;
      default: w_rst_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_rst     <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rid     <= '0;
      r_rresp   <= RESP_OK;
      r_ridx    <= '0;
      r_rrem    <= '0;
      r_rfixed  <= 1'b0;
      r_rlegal  <= 1'b0;
      r_fdata   <= '{default: '0};
      r_flast   <= '0;
      r_wp      <= 1'b0;
      r_rp      <= 1'b0;
      r_fcnt    <= '0;
    end else begin
      r_rst     <= w_rst_nxt;
      r_arready <= (w_rst_nxt == R_IDLE);
      r_rvalid  <= (w_fcnt_nxt != 2'd0);
      r_fcnt    <= w_fcnt_nxt;
      if (w_ar_hs) begin
        r_rid    <= s_axi_arid;
        r_ridx   <= w_ar_idx[IDX_W-1:0];
        r_rrem   <= {1'b0, s_axi_arlen} + 9'd1;
        r_rfixed <= (s_axi_arburst == 2'b00);
        r_rlegal <= w_ar_legal;
        r_rresp  <= w_ar_legal ? RESP_OK : RESP_SE;
      end
      if (w_r_issue) begin
        r_fdata[r_wp] <= r_rlegal ? r_mem[r_ridx] : '0;
        r_flast[r_wp] <= (r_rrem == 9'd1);
        r_wp          <= ~r_wp;
        r_rrem        <= r_rrem - 9'd1;
        if (!r_rfixed) r_ridx <= r_ridx + IDX_W'(1);
      end
      if (w_r_pop) r_rp <= ~r_rp;
    end
  end

  // ---------------- error counter ----------------
  logic [15:0] r_err;
  logic        w_err_w, w_err_r;
  logic [16:0] w_err_sum;

  // a wlast mismatch only counts when the burst was not already counted at AW
  assign w_err_w   = (w_aw_hs && !w_aw_legal) ||
                     (w_w_hs && w_wlast_beat && r_wlegal && (r_wlerr || w_wlast_err));
  assign w_err_r   = w_ar_hs && !w_ar_legal;
  assign w_err_sum = {1'b0, r_err} + 17'(w_err_w) + 17'(w_err_r);

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) r_err <= '0;
    else              r_err <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
  end

  assign s_axi_awready = r_awready;
  assign s_axi_wready  = r_wready;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bid     = r_bid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rid     = r_rid;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rdata   = r_fdata[r_rp];
  assign s_axi_rlast   = r_flast[r_rp];
  assign err_count     = r_err;
endmodule

// File: tb/tb_pcie_axib_mem_slave.sv
// Scoreboard bench for pcie_axib_mem_slave: directed bursts plus randomized traffic
// against a word-array reference model; monitors compare every B and R handshake.
`timescale 1ns/1ps
module tb_pcie_axib_mem_slave;
  localparam int          DW = 256, IW = 4, DEPTH = 64, NB = DW / 8;
  localparam logic [31:0] BASE = 32'h0001_0000;

  logic axi_aclk = 1'b0, axi_aresetn = 1'b0;
  logic [IW-1:0] s_axi_awid = '0, s_axi_arid = '0, s_axi_bid, s_axi_rid;
  logic [31:0]   s_axi_awaddr = '0, s_axi_araddr = '0;
  logic [7:0]    s_axi_awlen = '0, s_axi_arlen = '0;
  logic [2:0]    s_axi_awsize = '0, s_axi_arsize = '0;
  logic [1:0]    s_axi_awburst = '0, s_axi_arburst = '0, s_axi_bresp, s_axi_rresp;
  logic          s_axi_awvalid = 1'b0, s_axi_awready, s_axi_wlast = 1'b0, s_axi_wvalid = 1'b0;
  logic          s_axi_wready, s_axi_bvalid, s_axi_bready = 1'b0, s_axi_arvalid = 1'b0;
  logic          s_axi_arready, s_axi_rlast, s_axi_rvalid, s_axi_rready = 1'b0;
  logic [DW-1:0] s_axi_wdata = '0, s_axi_rdata;
  logic [NB-1:0] s_axi_wstrb = '0;
  logic [15:0]   err_count;

  always #2 axi_aclk = ~axi_aclk;

  pcie_axib_mem_slave #(.DATA_W(DW), .ADDR_W(32), .ID_W(IW), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .err_count(err_count)
  );

  typedef struct packed {logic [IW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last;} rexp_t;
  typedef struct packed {logic [IW-1:0] id; logic [1:0] resp;} bexp_t;

  rexp_t         r_q[$];
  bexp_t         b_q[$];
  logic [DW-1:0] mdl [DEPTH];
  logic [DW-1:0] wd [256];
  logic [NB-1:0] ws [256];
  int n_tests = 0, n_fail = 0, exp_err = 0, rr_mode = 1, br_mode = 1;
  bit gaps = 1'b0;

  task automatic chk(input string nm, input logic [299:0] got, input logic [299:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic bit legal(input logic [31:0] a, input int len, input logic [2:0] sz, input logic [1:0] bu);
    longint idx;
    if (sz != 3'd5 || bu > 2'd1 || a < BASE) return 1'b0;
    idx = longint'(a - BASE) / NB;
    if (idx >= DEPTH) return 1'b0;
    if (bu == 2'd1 && idx + len >= DEPTH) return 1'b0;
    return 1'b1;
  endfunction

  // ready drivers: 0 low, 1 high, 2 toggle, 3 random
  initial forever begin
    @(posedge axi_aclk); #1;
    case (rr_mode)
      0:       s_axi_rready = 1'b0;
      1:       s_axi_rready = 1'b1;
      2:       s_axi_rready = ~s_axi_rready;
      default: s_axi_rready = 1'($urandom_range(0, 1));
    endcase
    s_axi_bready = (br_mode == 1) ? 1'b1 : ($urandom_range(0, 2) != 0);
  end

  // monitor: a handshake seen at a negedge completes on the following posedge
  rexp_t cur, held;
  bexp_t bcur;
  bit    stall = 1'b0;
  initial forever begin
    @(negedge axi_aclk);
    if (!axi_aresetn) stall = 1'b0;
    else begin
      cur = {s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast};
      if (stall) chk("r_stable", {s_axi_rvalid, cur}, {1'b1, held});
      stall = s_axi_rvalid && !s_axi_rready;
      held  = cur;
      if (s_axi_rvalid && s_axi_rready) begin
        if (r_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL r_unexpected: got beat %0h, expected none", cur);
        end else chk("r_beat", cur, r_q.pop_front());
      end
      if (s_axi_bvalid && s_axi_bready) begin
        bcur = {s_axi_bid, s_axi_bresp};
        if (b_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL b_unexpected: got %0h, expected none", bcur);
        end else chk("b_resp", bcur, b_q.pop_front());
      end
    end
  end

  task automatic wait_rdy(input string nm, ref logic rdy);
    int n = 0;
    @(negedge axi_aclk);
    while (!rdy && n < 200) begin @(negedge axi_aclk); n++; end
    if (n >= 200) begin n_tests++; n_fail++; $display("FAIL %s_timeout: ready stayed 0, needed 1", nm); end
    @(posedge axi_aclk); #1;
  endtask

  task automatic send_aw(input logic [IW-1:0] id, input logic [31:0] a, input int len, input logic [1:0] bu, input logic [2:0] sz);
    s_axi_awid = id; s_axi_awaddr = a; s_axi_awlen = 8'(len); s_axi_awburst = bu; s_axi_awsize = sz;
    s_axi_awvalid = 1'b1;
    wait_rdy("aw", s_axi_awready);
    s_axi_awvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [IW-1:0] id, input logic [31:0] a, input int len, input logic [1:0] bu, input logic [2:0] sz);
    s_axi_arid = id; s_axi_araddr = a; s_axi_arlen = 8'(len); s_axi_arburst = bu; s_axi_arsize = sz;
    s_axi_arvalid = 1'b1;
    wait_rdy("ar", s_axi_arready);
    s_axi_arvalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((r_q.size() != 0 || b_q.size() != 0) && n < 500) begin @(posedge axi_aclk); n++; end
    if (n >= 500) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: %0d R / %0d B responses pending, expected 0", r_q.size(), b_q.size());
      r_q.delete(); b_q.delete();
    end
    repeat (2) @(posedge axi_aclk);
    #1 chk("err_count", err_count, 16'(exp_err));
  endtask

  // early < 0: wlast on the final beat; otherwise wlast only on beat 'early'
  task automatic do_write(input logic [IW-1:0] id, input logic [31:0] a, input int len,
                          input logic [1:0] bu, input logic [2:0] sz, input int early);
    bit     ok   = legal(a, len, sz, bu);
    bit     lerr = (early >= 0) && (early != len);
    longint k;
    bexp_t  e;
    if (ok)
      for (int i = 0; i <= len; i++) begin
        k = longint'(a - BASE) / NB + ((bu == 2'd0) ? 0 : i);
        for (int b = 0; b < NB; b++) if (ws[i][b]) mdl[k][b*8 +: 8] = wd[i][b*8 +: 8];
      end
    if (!ok || lerr) exp_err++;
    e.id = id; e.resp = (ok && !lerr) ? 2'b00 : 2'b10;
    b_q.push_back(e);
    send_aw(id, a, len, bu, sz);
    chk("wready_after_aw", s_axi_wready, 1'b1);
    for (int i = 0; i <= len; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge axi_aclk); #1; end
      s_axi_wvalid = 1'b1; s_axi_wdata = wd[i]; s_axi_wstrb = ws[i];
      s_axi_wlast  = (early >= 0) ? (i == early) : (i == len);
      wait_rdy("w", s_axi_wready);
      s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    end
    chk("bvalid_after_last_w", s_axi_bvalid, 1'b1);
    drain();
  endtask

  task automatic do_read(input logic [IW-1:0] id, input logic [31:0] a, input int len,
                         input logic [1:0] bu, input logic [2:0] sz);
    bit     ok = legal(a, len, sz, bu);
    longint k;
    rexp_t  e;
    if (!ok) exp_err++;
    for (int i = 0; i <= len; i++) begin
      k = longint'(a - BASE) / NB + ((bu == 2'd0) ? 0 : i);
      e.id = id; e.data = ok ? mdl[k] : '0; e.resp = ok ? 2'b00 : 2'b10; e.last = (i == len);
      r_q.push_back(e);
    end
    send_ar(id, a, len, bu, sz);
    chk("rvalid_ar+1", s_axi_rvalid, 1'b0);
    @(posedge axi_aclk); #1;
    chk("rvalid_ar+2", s_axi_rvalid, 1'b1);
    drain();
  endtask

  logic [DW-1:0] old_w, new_w;
  int r_len, r_sel, r_idx, r_early;
  logic [1:0] r_bu;
  logic [2:0] r_sz;

  initial begin
    #1;
    chk("reset_outs", {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid,
                       s_axi_rlast, s_axi_bresp, s_axi_rresp, s_axi_bid, s_axi_rid, err_count}, '0);
    chk("reset_rdata", s_axi_rdata, '0);
    repeat (3) @(negedge axi_aclk);
    axi_aresetn = 1'b1;
    @(posedge axi_aclk); #1;
    chk("ready_after_reset", {s_axi_awready, s_axi_arready}, 2'b11);

    // fill the whole memory so every later read has a defined model value
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < 8; j++) wd[i][j*32 +: 32] = $urandom;
      ws[i] = '1;
    end
    do_write(0, BASE, DEPTH - 1, 2'd1, 3'd5, -1);

    // INCR write/read at BASE+0x40
    for (int i = 0; i < 4; i++) begin wd[i] = DW'(8'hA0 + i); ws[i] = '1; end
    do_write(1, BASE + 32'h40, 3, 2'd1, 3'd5, -1);
    do_read(1, BASE + 32'h40, 3, 2'd1, 3'd5);

    // 8-beat read under toggling rready
    for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) wd[i][j*32 +: 32] = $urandom;
    do_write(2, BASE + 30 * NB, 7, 2'd1, 3'd5, -1);
    rr_mode = 2;
    do_read(2, BASE + 30 * NB, 7, 2'd1, 3'd5);
    rr_mode = 1;

    // partial strobe over all-ones
    wd[0] = '1; ws[0] = '1;
    do_write(3, BASE + 40 * NB, 0, 2'd1, 3'd5, -1);
    for (int j = 0; j < 8; j++) wd[0][j*32 +: 32] = $urandom;
    ws[0] = 32'h0000_000F;
    do_write(3, BASE + 40 * NB, 0, 2'd1, 3'd5, -1);
    do_read(3, BASE + 40 * NB, 0, 2'd1, 3'd5);

    // FIXED burst: index 5 ends with the last beat, 6..8 untouched
    for (int i = 0; i < 4; i++) begin wd[i] = DW'(i + 1); ws[i] = '1; end
    do_write(4, BASE + 5 * NB, 3, 2'd0, 3'd5, -1);
    do_read(4, BASE + 5 * NB, 0, 2'd1, 3'd5);
    do_read(4, BASE + 6 * NB, 2, 2'd1, 3'd5);

    // out of range and WRAP
    for (int i = 0; i < 4; i++) begin wd[i] = '1; ws[i] = '1; end
    do_write(5, BASE + (DEPTH - 2) * NB, 3, 2'd1, 3'd5, -1);
    chk("err_oor_write", err_count, 16'd1);
    do_read(5, BASE + (DEPTH - 2) * NB, 3, 2'd1, 3'd5);
    chk("err_oor_read", err_count, 16'd2);
    do_write(6, BASE, 3, 2'd2, 3'd5, -1);
    chk("err_wrap", err_count, 16'd3);
    do_read(6, BASE + (DEPTH - 2) * NB, 1, 2'd1, 3'd5);

    // early wlast on beat 2 of 4
    for (int i = 0; i < 4; i++) begin wd[i] = DW'(32'hC0DE_0000 + i); ws[i] = '1; end
    do_write(7, BASE + 12 * NB, 3, 2'd1, 3'd5, 1);
    chk("err_early_wlast", err_count, 16'd4);
    do_read(7, BASE + 12 * NB, 3, 2'd1, 3'd5);

    // write and read of one word on the same edge: read sees the old word
    old_w = mdl[20];
    for (int j = 0; j < 8; j++) new_w[j*32 +: 32] = $urandom;
    r_q.push_back('{id: 4'd8, data: old_w, resp: 2'b00, last: 1'b1});
    b_q.push_back('{id: 4'd9, resp: 2'b00});
    mdl[20] = new_w;
    send_aw(9, BASE + 20 * NB, 0, 2'd1, 3'd5);
    send_ar(8, BASE + 20 * NB, 0, 2'd1, 3'd5);
    s_axi_wvalid = 1'b1; s_axi_wdata = new_w; s_axi_wstrb = '1; s_axi_wlast = 1'b1;
    @(posedge axi_aclk); #1;
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    drain();
    do_read(8, BASE + 20 * NB, 0, 2'd1, 3'd5);

    // randomized traffic
    gaps = 1'b1; rr_mode = 3; br_mode = 0;
    for (int t = 0; t < 40; t++) begin
      r_len = $urandom_range(0, 7);
      r_sel = $urandom_range(0, 9);
      r_bu  = (r_sel == 0) ? 2'd2 : 2'($urandom_range(0, 1));
      r_sz  = (r_sel == 1) ? 3'd4 : 3'd5;
      r_idx = (r_sel == 2) ? $urandom_range(DEPTH - 4, DEPTH + 4) : $urandom_range(0, DEPTH - 9);
      r_early = (r_sel == 3) ? $urandom_range(0, r_len) : -1;
      for (int i = 0; i <= r_len; i++) begin
        for (int j = 0; j < 8; j++) wd[i][j*32 +: 32] = $urandom;
        ws[i] = ($urandom_range(0, 3) == 0) ? NB'($urandom) : '1;
      end
      if ($urandom_range(0, 1) != 0)
        do_write(IW'($urandom), BASE + 32'(r_idx * NB), r_len, r_bu, r_sz, r_early);
      else
        do_read(IW'($urandom), BASE + 32'(r_idx * NB), r_len, r_bu, r_sz);
    end
    gaps = 1'b0; br_mode = 1;

    // reset in the middle of a stalled read burst
    rr_mode = 0;
    repeat (3) @(posedge axi_aclk); #1;
    send_ar(10, BASE + 32'h40, 7, 2'd1, 3'd5);
    repeat (4) @(posedge axi_aclk); #1;
    axi_aresetn = 1'b0;
    #1;
    chk("reset_mid_read", {s_axi_rvalid, s_axi_arready, s_axi_awready, err_count}, '0);
    exp_err = 0;
    @(negedge axi_aclk); @(negedge axi_aclk);
    axi_aresetn = 1'b1;
    @(posedge axi_aclk); #1;
    chk("ready_after_mid_reset", {s_axi_awready, s_axi_arready}, 2'b11);
    rr_mode = 1;
    repeat (2) @(posedge axi_aclk); #1;
    do_read(11, BASE + 32'h40, 3, 2'd1, 3'd5);
    do_read(11, BASE, 15, 2'd1, 3'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end
endmodule

// File: doc/pcie_axib_mem_slave.md
# pcie_axib_mem_slave

Parametrised AXI4 memory-mapped slave that terminates the XDMA `m_axib` bypass master, which is otherwise tied off. It provides a BAR-mapped scratch memory of configurable width and depth with INCR and FIXED bursts and independent read and write engines. It flags illegal transactions with SLVERR and counts them. It sits beside the XDMA core in the PCIe subsystem, in the 250 MHz `axi_aclk` domain.

## Interface
- `DATA_W`, 256: data width in bits; one of 32, 64, 128, 256, 512.
- `ADDR_W`, 32: address width.
- `ID_W`, 4: AXI ID width.
- `DEPTH`, 1024: memory depth in `DATA_W` words; power of two.
- `BASE_ADDR`, 0: byte base address; aligned to `DEPTH*DATA_W/8`.
- `axi_aclk`  in  1  clock, 250 MHz.
- `axi_aresetn`  in  1  reset; asynchronous assert, active-low.
- `s_axi_awid/awaddr/awlen/awsize/awburst`  in  ID_W/ADDR_W/8/3/2  write address payload.
- `s_axi_awvalid` in 1; `s_axi_awready` out 1.
- `s_axi_wdata/wstrb/wlast`  in  DATA_W/DATA_W/8/1  write data payload.
- `s_axi_wvalid` in 1; `s_axi_wready` out 1.
- `s_axi_bid/bresp`  out  ID_W/2  write response.
- `s_axi_bvalid` out 1; `s_axi_bready` in 1.
- `s_axi_arid/araddr/arlen/arsize/arburst`  in  ID_W/ADDR_W/8/3/2  read address payload.
- `s_axi_arvalid` in 1; `s_axi_arready` out 1.
- `s_axi_rid/rdata/rresp/rlast`  out  ID_W/DATA_W/2/1  read data payload.
- `s_axi_rvalid` out 1; `s_axi_rready` in 1.
- `err_count`  out  16  count of SLVERR bursts; saturates at 0xFFFF.

## Operation
- **Memory.** Simple dual-port: one write port, one read port, one-cycle registered read. Word index = (addr − BASE_ADDR) >> log2(DATA_W/8). On a same-cycle read and write of one word, the read returns the old data.
- **Burst checks at address handshake.** A burst is illegal if any of the following holds:
  - size ≠ log2(DATA_W/8);
  - burst = WRAP or reserved (2'b10, 2'b11);
  - start index ≥ DEPTH;
  - INCR and start + len ≥ DEPTH.
  - Illegal bursts respond SLVERR, suppress memory writes, and return rdata = 0 on every beat. `err_count` increments once per illegal burst.
- **Addressing.** INCR: index += 1 per beat. FIXED: index is constant for the burst.
- **Write FSM: W_IDLE → W_DATA → W_RESP → W_IDLE.**
  - W_IDLE: awready=1. AW handshake latches id, index, len, burst, and legality.
  - W_DATA: wready=1. Each W handshake writes the bytes enabled by wstrb (if legal) and decrements the beat count. The burst ends on beat len+1 by count, regardless of wlast.
  - If wlast does not equal (beat == last) on any beat, bresp = SLVERR and `err_count` increments. Writes still occur if the burst is otherwise legal.
  - W_RESP: bvalid=1 with the latched bid and bresp, held until bready.
- **Read FSM: R_IDLE → R_BURST → R_IDLE.**
  - R_IDLE: arready=1. AR handshake latches the burst fields.
  - R_BURST: the engine issues memory reads into a 2-entry output FIFO. It issues only when the FIFO has room counting in-flight reads, so nothing is dropped under rready backpressure.
  - rlast is set on beat len+1. rresp = OKAY or SLVERR, constant for the whole burst. rid = latched arid.
- Read and write engines are fully independent; one outstanding burst per direction.
- **Reset** (any time, including mid-burst): FSMs go to IDLE, the FIFO empties, and `err_count` = 0. Memory contents are retained. An aborted write burst may have partially written memory.

## Timing
- During reset, every output is 0, including awready and arready.
- awready and arready rise on the first `axi_aclk` rising edge after `axi_aresetn` deasserts.
- Write:
  - AW handshake at cycle T → wready=1 at T+1.
  - Last W handshake at cycle U → bvalid=1 at U+1.
  - B handshake at cycle V → awready=1 at V+1.
- Read:
  - AR handshake at cycle T → first rvalid at T+2.
  - With rready held high, beats are back-to-back at one per cycle.
  - rvalid and payload stay stable while rready=0.
  - The handshake of the rlast beat at cycle V → arready=1 at V+1.
- All outputs are registered. There are no combinational valid→ready paths.
- `err_count` updates one cycle after the handshake that decides the error (AW/AR handshake, or the last W handshake).

## Test plan
- **INCR write/read.** INCR write awaddr=BASE+0x40, awlen=3, wstrb all-ones, data 0xA0..0xA3 → bresp=OKAY. Then an INCR read of the same range → rdata 0xA0..0xA3, rlast on beat 4, first rvalid at AR handshake +2.
- **Backpressure and strobes.** Toggle rready 1-0-1-0 during an 8-beat read → no lost or duplicated beats. Then a partial write with wstrb=0x0000000F over 0xFF..FF → only the low 4 bytes change on read-back.
- **FIXED burst.** FIXED write awlen=3, data 1,2,3,4 at index 5 → a read of index 5 returns 4, and indices 6–8 are unchanged.
- **Out of range.** INCR write with start index DEPTH−2, awlen=3 → bresp=SLVERR, memory unchanged, err_count=1. Read of the same burst → 4 beats with rdata=0 and rresp=SLVERR, err_count=2. WRAP burst → SLVERR, err_count=3.
- **Early wlast.** wlast asserted on beat 2 of a 4-beat burst → 4 beats accepted, bresp=SLVERR, err_count increments.
- **Reset and concurrency.**
  - Assert axi_aresetn low mid-read-burst → rvalid=0 immediately; after release, arready=1 and data written before the reset is intact.
  - Simultaneous write and read of one word → the read returns the old value.
